// File: rtl/mult_block_buffer.sv
// Multiply-and-store block: 3-stage signed/unsigned multiplier that fills an external
// 2^LOGDEPTH-entry memory in order, then streams the stored block back on request.
module mult_block_buffer #(
    parameter int LOGDEPTH  = 6,
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 2*IN_WIDTH,
    parameter int MEM_LAT   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  EN_mult,
    input  logic                  mult_signed,
    input  logic [IN_WIDTH-1:0]   mult_input0,
    input  logic [IN_WIDTH-1:0]   mult_input1,
    output logic                  RDY_mult,
    output logic                  EN_writeMem,
    output logic [LOGDEPTH-1:0]   writeMem_addr,
    output logic [OUT_WIDTH-1:0]  writeMem_val,
    input  logic                  EN_blockRead,
    output logic                  RDY_blockRead,
    output logic                  EN_readMem,
    output logic [LOGDEPTH-1:0]   readMem_addr,
    input  logic [OUT_WIDTH-1:0]  readMem_val,
    output logic                  VALID_memVal,
    output logic [OUT_WIDTH-1:0]  memVal_data,
    output logic [LOGDEPTH:0]     fill_count
);

    localparam int STAGES = 2;
    localparam int PW     = 2*IN_WIDTH;
    localparam int CW     = LOGDEPTH + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(1 << LOGDEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    typedef enum logic [1:0] {IDLE, FILL, FULL, DRAIN} state_t;

    typedef struct packed {
        logic                sgn;
        logic [IN_WIDTH-1:0] a;
        logic [IN_WIDTH-1:0] b;
    } opnd_t;

    state_t               state, state_nxt;
    logic [STAGES:0]      vld_pipe;
    opnd_t                s1;
    logic [OUT_WIDTH-1:0] s2_prod, s3_val;
    logic [CW-1:0]        issued, wr_cnt, rd_idx, drain_n, val_cnt;
    logic [MEM_LAT-1:0]   rd_tag;

    logic                 pipe_empty, rdy_br, br_acc, rdy_mult, accept;
    logic                 wr_en, rd_en, mem_vld, drain_last;
    logic [PW-1:0]        a_ext, b_ext, prod;
    logic [OUT_WIDTH-1:0] prod_ext;

    // Handshakes; every control output is forced low while rst is high.
    always_comb begin
        pipe_empty = ~|vld_pipe;
        rdy_br     = ~rst & ((state == FULL) |
                             ((state == FILL) & pipe_empty & (wr_cnt != '0)));
        br_acc     = EN_blockRead & rdy_br;
        rdy_mult   = ~rst & ((state == IDLE) | (state == FILL)) &
                     (issued < DEPTH_C) & ~br_acc;
        accept     = EN_mult & rdy_mult;
        wr_en      = ~rst & vld_pipe[STAGES];
        rd_en      = ~rst & (state == DRAIN) & (rd_idx < drain_n);
        mem_vld    = ~rst & rd_tag[MEM_LAT-1];
        drain_last = mem_vld & (val_cnt == drain_n - ONE_C);
    end

    // A single 2W x 2W multiplier covers both modes: the low 2W bits of the
    // product of the sign- or zero-extended operands are the exact result.
    always_comb begin
        a_ext    = {{IN_WIDTH{s1.sgn & s1.a[IN_WIDTH-1]}}, s1.a};
        b_ext    = {{IN_WIDTH{s1.sgn & s1.b[IN_WIDTH-1]}}, s1.b};
        prod     = a_ext * b_ext;
        prod_ext = s1.sgn ? OUT_WIDTH'($signed(prod)) : OUT_WIDTH'(prod);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (accept) state_nxt = FILL;
            FILL: begin
                if (br_acc)
                    state_nxt = DRAIN;
                else if (wr_en && (wr_cnt == DEPTH_C - ONE_C))
                    state_nxt = FULL;
            end
            FULL:  if (br_acc) state_nxt = DRAIN;
            DRAIN: if (drain_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            vld_pipe <= '0;
            issued   <= '0;
            wr_cnt   <= '0;
            rd_idx   <= '0;
            drain_n  <= '0;
            val_cnt  <= '0;
            rd_tag   <= '0;
        end else begin
            state    <= state_nxt;
            vld_pipe <= {vld_pipe[STAGES-1:0], accept};
            if (accept)  issued  <= issued + ONE_C;
            if (wr_en)   wr_cnt  <= wr_cnt + ONE_C;
            if (rd_en)   rd_idx  <= rd_idx + ONE_C;
            if (mem_vld) val_cnt <= val_cnt + ONE_C;
            if (br_acc) begin
                drain_n <= wr_cnt;
                rd_idx  <= '0;
                val_cnt <= '0;
            end
            if (drain_last) begin
                issued  <= '0;
                wr_cnt  <= '0;
                rd_idx  <= '0;
                val_cnt <= '0;
                drain_n <= '0;
            end
            // Read tags model the memory latency so VALID lines up with readMem_val.
            rd_tag[0] <= rd_en;
            for (int i = 1; i < MEM_LAT; i++)
                rd_tag[i] <= rd_tag[i-1];
        end
    end

    // Datapath registers are qualified by vld_pipe and need no reset.
    always_ff @(posedge clk) begin
        if (accept) s1 <= '{sgn: mult_signed, a: mult_input0, b: mult_input1};
        s2_prod <= prod_ext;
        s3_val  <= s2_prod;
    end

    // Writes are in order, so the completed-write count is the next address.
    assign RDY_mult      = rdy_mult;
    assign RDY_blockRead = rdy_br;
    assign EN_writeMem   = wr_en;
    assign writeMem_addr = wr_en ? wr_cnt[LOGDEPTH-1:0] : '0;
    assign writeMem_val  = wr_en ? s3_val : '0;
    assign EN_readMem    = rd_en;
    assign readMem_addr  = rd_en ? rd_idx[LOGDEPTH-1:0] : '0;
    assign VALID_memVal  = mem_vld;
    assign memVal_data   = mem_vld ? readMem_val : '0;
    assign fill_count    = rst ? '0 : wr_cnt;

endmodule

// File: tb/tb_mult_block_buffer.sv
// Directed bench for mult_block_buffer with a memory model and write/read scoreboards.
module tb_mult_block_buffer;

    localparam int LOGD = 6;
    localparam int IW   = 16;
    localparam int OW   = 32;
    localparam int ML   = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            EN_mult = 1'b0, mult_signed = 1'b0;
    logic [IW-1:0]   mult_input0 = '0, mult_input1 = '0;
    logic            RDY_mult, EN_writeMem, EN_blockRead = 1'b0, RDY_blockRead;
    logic [LOGD-1:0] writeMem_addr, readMem_addr;
    logic [OW-1:0]   writeMem_val, readMem_val, memVal_data;
    logic            EN_readMem, VALID_memVal;
    logic [LOGD:0]   fill_count;

    mult_block_buffer #(.LOGDEPTH(LOGD), .IN_WIDTH(IW), .OUT_WIDTH(OW), .MEM_LAT(ML)) dut (
        .clk(clk), .rst(rst),
        .EN_mult(EN_mult), .mult_signed(mult_signed),
        .mult_input0(mult_input0), .mult_input1(mult_input1), .RDY_mult(RDY_mult),
        .EN_writeMem(EN_writeMem), .writeMem_addr(writeMem_addr), .writeMem_val(writeMem_val),
        .EN_blockRead(EN_blockRead), .RDY_blockRead(RDY_blockRead),
        .EN_readMem(EN_readMem), .readMem_addr(readMem_addr), .readMem_val(readMem_val),
        .VALID_memVal(VALID_memVal), .memVal_data(memVal_data), .fill_count(fill_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // External memory with a two-cycle read path.
    logic [OW-1:0] mem [64];
    logic [OW-1:0] rd_p1, rd_p2;
    always @(posedge clk) begin
        if (EN_writeMem) mem[writeMem_addr] <= writeMem_val;
        if (EN_readMem)  rd_p1 <= mem[readMem_addr];
        rd_p2 <= rd_p1;
    end
    assign readMem_val = rd_p2;

    typedef struct { logic [LOGD-1:0] addr; logic [OW-1:0] val; int cyc; } wr_t;
    typedef struct { logic [OW-1:0] val; int cyc; } rd_t;
    wr_t wq[$];
    rd_t rq[$];

    int vectors = 0, miscompares = 0;
    int exp_wr_addr = 0, drain_n = 0, reads_seen = 0, valids_seen = 0;
    int exp_rd_addr = 0, br_cyc = 0, last_rd_cyc = 0;

    logic [IW-1:0] ta [6] = '{16'hFFFF, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h8000, 16'h7FFF};
    logic [IW-1:0] tb [6] = '{16'hFFFF, 16'h0002, 16'h7FFF, 16'hFFFF, 16'h0002, 16'h7FFF};
    logic          ts [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [OW-1:0] te [6] = '{32'h00000001, 32'hFFFF0000, 32'h3FFF0001,
                              32'hFFFE0001, 32'h00010000, 32'h3FFF0001};

    function automatic logic [OW-1:0] golden(input logic [IW-1:0] a, input logic [IW-1:0] b,
                                             input logic s);
        longint pa, pb, p;
        pa = s ? longint'($signed(a)) : longint'({48'd0, a});
        pb = s ? longint'($signed(b)) : longint'({48'd0, b});
        p  = pa * pb;
        return p[OW-1:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_drain(input int n);
        int k = 0;
        while (k < 400 && valids_seen != n) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk("drain_valids", 64'(valids_seen), 64'(n));
        chk("drain_reads", 64'(reads_seen), 64'(n));
        @(negedge clk);
        chk("idle_fill", 64'(fill_count), 64'd0);
        chk("idle_rdy_mult", 64'(RDY_mult), 64'd1);
        tick();
    endtask

    // Monitor: checks reset outputs, pops scoreboards on DUT output, pushes on accepts.
    initial begin
        wr_t w;
        rd_t r;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_ctl", 64'({RDY_mult, RDY_blockRead, EN_writeMem, EN_readMem, VALID_memVal,
                                    writeMem_addr, readMem_addr, fill_count}), 64'd0);
                chk("rst_data", 64'({writeMem_val, memVal_data}), 64'd0);
                wq.delete(); rq.delete();
                exp_wr_addr = 0; drain_n = 0; reads_seen = 0; valids_seen = 0;
            end else begin
                chk("wr_rd_excl", 64'(EN_writeMem & EN_readMem), 64'd0);
                if (EN_writeMem) begin
                    vectors++;
                    assert (wq.size() > 0) else begin
                        miscompares++;
                        $error("FAIL wr_unexpected: observed write addr %0d expected none", writeMem_addr);
                    end
                    if (wq.size() > 0) begin
                        w = wq.pop_front();
                        chk("wr_addr", 64'(writeMem_addr), 64'(w.addr));
                        chk("wr_val", 64'(writeMem_val), 64'(w.val));
                        chk("wr_cyc", 64'(cyc), 64'(w.cyc));
                    end
                end
                if (VALID_memVal) begin
                    vectors++;
                    assert (rq.size() > 0) else begin
                        miscompares++;
                        $error("FAIL val_unexpected: observed data %0h expected none", memVal_data);
                    end
                    if (rq.size() > 0) begin
                        r = rq.pop_front();
                        chk("memval_data", 64'(memVal_data), 64'(r.val));
                        chk("memval_cyc", 64'(cyc), 64'(r.cyc));
                    end
                    valids_seen++;
                    if (valids_seen == drain_n) exp_wr_addr = 0;
                end else begin
                    chk("memval_idle", 64'(memVal_data), 64'd0);
                end
                if (EN_readMem) begin
                    chk("rd_addr", 64'(readMem_addr), 64'(exp_rd_addr));
                    chk("rd_cyc", 64'(cyc), 64'((reads_seen == 0) ? br_cyc + 1 : last_rd_cyc + 1));
                    rq.push_back('{val: mem[readMem_addr], cyc: cyc + ML});
                    exp_rd_addr++; reads_seen++; last_rd_cyc = cyc;
                end
                if (EN_mult && RDY_mult) begin
                    wq.push_back('{addr: LOGD'(exp_wr_addr),
                                   val: golden(mult_input0, mult_input1, mult_signed),
                                   cyc: cyc + 3});
                    exp_wr_addr++;
                end
                if (EN_blockRead && RDY_blockRead) begin
                    drain_n = exp_wr_addr; reads_seen = 0; valids_seen = 0;
                    exp_rd_addr = 0; br_cyc = cyc;
                end
            end
        end
    end

    initial begin
        // Reset, then a full block of unsigned (i, i+1) pairs.
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_rdy_mult", 64'(RDY_mult), 64'd1);
        chk("post_rst_rdy_br", 64'(RDY_blockRead), 64'd0);
        tick();
        for (int i = 0; i < 64; i++) begin
            EN_mult = 1'b1; mult_signed = 1'b0;
            mult_input0 = IW'(i); mult_input1 = IW'(i + 1);
            @(negedge clk);
            chk("fill_rdy_mult", 64'(RDY_mult), 64'd1);
            tick();
        end
        @(negedge clk);
        chk("rdy_mult_after_64", 64'(RDY_mult), 64'd0);
        tick();
        EN_mult = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        chk("full_fill_count", 64'(fill_count), 64'd64);
        chk("full_rdy_br", 64'(RDY_blockRead), 64'd1);
        chk("full_rdy_mult", 64'(RDY_mult), 64'd0);
        tick();
        chk("full_wq_empty", 64'(wq.size()), 64'd0);

        // Full drain; EN_mult and EN_blockRead during DRAIN must be ignored.
        EN_blockRead = 1'b1;
        tick();
        EN_blockRead = 1'b0; EN_mult = 1'b1;
        repeat (3) tick();
        EN_blockRead = 1'b1;
        @(negedge clk);
        chk("drain_rdy_br", 64'(RDY_blockRead), 64'd0);
        chk("drain_rdy_mult", 64'(RDY_mult), 64'd0);
        tick();
        EN_blockRead = 1'b0; EN_mult = 1'b0;
        wait_drain(64);

        // Signed and unsigned corner operands, then a partial drain of 6.
        for (int i = 0; i < 6; i++) begin
            EN_mult = 1'b1; mult_signed = ts[i];
            mult_input0 = ta[i]; mult_input1 = tb[i];
            tick();
        end
        EN_mult = 1'b0;
        repeat (5) tick();
        @(negedge clk);
        for (int i = 0; i < 6; i++) chk("mem_corner", 64'(mem[i]), 64'(te[i]));
        chk("part6_fill", 64'(fill_count), 64'd6);
        chk("part6_rdy_br", 64'(RDY_blockRead), 64'd1);
        tick();
        EN_blockRead = 1'b1;
        tick();
        EN_blockRead = 1'b0;
        wait_drain(6);

        // Partial block of 5; read request beats a same-cycle multiply.
        for (int i = 0; i < 5; i++) begin
            EN_mult = 1'b1; mult_signed = 1'($urandom_range(1));
            mult_input0 = IW'($urandom); mult_input1 = IW'($urandom);
            tick();
        end
        EN_mult = 1'b0;
        repeat (5) tick();
        @(negedge clk);
        chk("part5_rdy_br", 64'(RDY_blockRead), 64'd1);
        tick();
        EN_mult = 1'b1; EN_blockRead = 1'b1;
        @(negedge clk);
        chk("same_cyc_rdy_mult", 64'(RDY_mult), 64'd0);
        chk("same_cyc_rdy_br", 64'(RDY_blockRead), 64'd1);
        tick();
        EN_mult = 1'b0; EN_blockRead = 1'b0;
        tick();
        EN_blockRead = 1'b1;
        @(negedge clk);
        chk("part5_drain_rdy_br", 64'(RDY_blockRead), 64'd0);
        tick();
        EN_blockRead = 1'b0;
        wait_drain(5);

        // Next block starts at addr 0; reset with fill_count=30 and the pipeline full.
        for (int i = 0; i < 34; i++) begin
            EN_mult = 1'b1; mult_signed = 1'($urandom_range(1));
            mult_input0 = IW'($urandom); mult_input1 = IW'($urandom);
            @(negedge clk);
            if (i == 33) chk("midfill_count", 64'(fill_count), 64'd30);
            tick();
        end
        EN_mult = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_fill_rst_wr", 64'(EN_writeMem), 64'd0);
            chk("post_fill_rst_cnt", 64'(fill_count), 64'd0);
            tick();
        end

        // Reset mid-drain with reads and read tags in flight.
        for (int i = 0; i < 10; i++) begin
            EN_mult = 1'b1; mult_signed = 1'b0;
            mult_input0 = IW'(3 * i); mult_input1 = IW'(i + 7);
            tick();
        end
        EN_mult = 1'b0;
        repeat (5) tick();
        EN_blockRead = 1'b1;
        tick();
        EN_blockRead = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_drain_rst_vld", 64'(VALID_memVal), 64'd0);
            chk("post_drain_rst_rd", 64'(EN_readMem), 64'd0);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            EN_mult = 1'b1; mult_signed = 1'b1;
            mult_input0 = IW'(16'hFFF0 + i); mult_input1 = IW'(i + 5);
            tick();
        end
        EN_mult = 1'b0;
        repeat (6) tick();
        @(negedge clk);
        chk("restart_fill", 64'(fill_count), 64'd2);
        chk("end_wq_empty", 64'(wq.size()), 64'd0);
        chk("end_rq_empty", 64'(rq.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mult_block_buffer.md
Name: mult_block_buffer

Overview:
Parametrised successor to the team's fixed 16x16 multiply-and-store block. It accepts operand pairs over a valid/ready handshake and multiplies them, signed or unsigned per operation, through a 3-stage pipeline. Products are written sequentially into an external 2^LOGDEPTH-entry memory. On request it streams the stored block back out, either full or partial, with a configurable memory read latency.

Parameters:
LOGDEPTH, 6, log2 of block depth; DEPTH = 2^LOGDEPTH entries
IN_WIDTH, 16, operand width in bits
OUT_WIDTH, 2*IN_WIDTH, product/memory word width; must be >= 2*IN_WIDTH
MEM_LAT, 1, external memory read latency in cycles, >= 1

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high
EN_mult  input  1  operand pair valid
mult_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with the operands
mult_input0  input  IN_WIDTH  operand A
mult_input1  input  IN_WIDTH  operand B
RDY_mult  output  1  block can accept an operand pair
EN_writeMem  output  1  memory write strobe
writeMem_addr  output  LOGDEPTH  write address
writeMem_val  output  OUT_WIDTH  product to write
EN_blockRead  input  1  request readout of the stored block
RDY_blockRead  output  1  readout request can be accepted
EN_readMem  output  1  memory read strobe
readMem_addr  output  LOGDEPTH  read address
readMem_val  input  OUT_WIDTH  memory data, valid MEM_LAT cycles after EN_readMem
VALID_memVal  output  1  memVal_data is valid
memVal_data  output  OUT_WIDTH  readout data
fill_count  output  LOGDEPTH+1  entries written in the current block

Behaviour:
- Reset while rst=1 (including mid-fill or mid-drain):
  - state IDLE, pipeline valids cleared, issue and write counters cleared, in-flight read tags cleared.
  - All outputs 0 during the rst cycle, including RDY_mult and RDY_blockRead.
- Accept rule: an operand pair is accepted on a cycle with EN_mult & RDY_mult.
- RDY_mult = (state IDLE or FILL) & issued < DEPTH & ~(EN_blockRead & RDY_blockRead). A read request therefore has priority over a same-cycle multiply.
- Pipeline, with one valid bit per stage:
  - S1 registers operands and the mode bit.
  - S2 registers the sign-/zero-extended full product.
  - S3 drives EN_writeMem, writeMem_val and writeMem_addr.
  - A pair accepted in cycle t is written in cycle t+3.
  - Back-to-back accepts give one write per cycle, no bubbles.
- Arithmetic:
  - Product is an exact 2*IN_WIDTH-bit result, sign- or zero-extended to OUT_WIDTH per mult_signed.
  - Example (IN_WIDTH=16): signed -1 x -1 = 0x00000001; unsigned 0xFFFF x 0xFFFF = 0xFFFE0001.
- Write addresses run 0,1,...,DEPTH-1 in acceptance order; they never wrap within a block. fill_count increments on each write.
- States:
  - IDLE: first accept moves to FILL.
  - FILL: when the write to DEPTH-1 completes (fill_count = DEPTH) the next state is FULL.
  - FULL: RDY_mult=0; EN_blockRead moves to DRAIN.
  - DRAIN: RDY_mult=0, RDY_blockRead=0, EN_blockRead ignored.
- RDY_blockRead = FULL | (FILL & all pipeline stages empty & fill_count > 0). This enables a partial-block drain.
- Drain sequence:
  - N = fill_count latched on entry.
  - EN_readMem is asserted for N consecutive cycles, addr 0..N-1, starting the cycle after acceptance.
  - VALID_memVal is asserted exactly MEM_LAT cycles after each EN_readMem.
  - memVal_data = readMem_val when VALID_memVal, else 0.
  - The cycle after the last VALID_memVal: state IDLE, fill_count=0, counters cleared, RDY_mult=1.
- EN_mult while RDY_mult=0 is ignored; nothing is dropped silently once accepted.
- writeMem and readMem are never both asserted in the same cycle.

Test Plan:
- Reset then 64 back-to-back unsigned pairs (i, i+1), i=0..63 -> writes at addr i with value i*(i+1), first write 3 cycles after first accept; RDY_mult falls after the 64th accept; FULL reached with fill_count=64.
- Signed mode: (0xFFFF,0xFFFF), (0x8000,0x0002), (0x7FFF,0x7FFF) -> 0x00000001, 0xFFFF0000, 0x3FFF0001; the same operands unsigned -> 0xFFFE0001, 0x00010000, 0x3FFF0001.
- Full drain with MEM_LAT=2 from FULL -> EN_readMem for 64 cycles with addr 0..63; VALID_memVal for 64 cycles lagging by 2; memVal_data equals the memory model; then IDLE, fill_count=0.
- Partial block: 5 accepts, wait for the pipeline to empty, then EN_blockRead -> RDY_blockRead=1 beforehand, exactly 5 reads at addr 0..4, 5 valids, back to IDLE; the next accept writes addr 0.
- Same-cycle EN_mult and EN_blockRead in FILL with the pipeline empty -> read accepted, mult not accepted (RDY_mult=0 that cycle), no write occurs; EN_blockRead asserted during DRAIN has no effect.
- rst asserted mid-fill (fill_count=30, pipeline full) and mid-drain -> all outputs 0 next cycle, no further EN_writeMem or VALID_memVal from stale pipeline/read tags; the next block starts at addr 0.
